rf_dump_ctrl: RTL and testbench
===============================

Name: rf_dump_ctrl

Overview:
- Read-side initiator for the 32-entry register file: on a start pulse, sweeps all 32 registers through the two read ports (s = even, t = odd) and streams {address, data} out over a valid/ready interface.
- Used for debug/state dump and for self-checking benches: the write path fills the file, and this block reads it back in order.
- Drives the register file's read_enabled, read_addr_s and read_addr_t. Consumes its outA and outB outputs.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width. The file depth is 2**ADDR_WIDTH = 32.
- READ_LATENCY, 1, clock cycles from a stable address with read_enabled high to valid outA/outB. Legal range 1..4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump. Sampled only in IDLE.
- read_enabled  out  1  register file read enable.
- read_addr_s  out  ADDR_WIDTH  register file port-s address; always even.
- read_addr_t  out  ADDR_WIDTH  register file port-t address; always read_addr_s+1.
- outA  in  DATA_WIDTH  register file port-s read data.
- outB  in  DATA_WIDTH  register file port-t read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word when high with out_valid.
- out_addr  out  ADDR_WIDTH  register index of the current word.
- out_data  out  DATA_WIDTH  register contents.
- out_last  out  1  high with the word for register 31.
- busy  out  1  high in every state except IDLE.
- finish  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (asynchronous, applies immediately, including mid-dump):
  - state = IDLE, pair counter = 0, wait counter = 0, capture buffers = 0.
  - All outputs low or zero; read addresses = 0.
  - A dump interrupted by reset is abandoned and is not resumed.
- States: IDLE, ISSUE, EMIT_S, EMIT_T, DONE.
- IDLE:
  - start=1 → ISSUE; pair counter p = 0; wait counter = READ_LATENCY-1.
  - start=0 → stay in IDLE.
- ISSUE:
  - read_enabled=1, read_addr_s=2p, read_addr_t=2p+1.
  - Addresses stay stable for READ_LATENCY cycles.
  - Wait counter decrements each cycle. On the edge where it is 0: buf_s ← outA, buf_t ← outB, → EMIT_S.
- EMIT_S:
  - out_valid=1, out_addr=2p, out_data=buf_s, out_last=0.
  - out_ready=1 → EMIT_T. Otherwise hold every output stable.
- EMIT_T:
  - out_valid=1, out_addr=2p+1, out_data=buf_t, out_last=(p==15).
  - On out_ready=1:
    - if p==15 → DONE;
    - else p ← p+1, wait counter reloaded to READ_LATENCY-1, → ISSUE.
- DONE:
  - finish=1 for exactly one cycle, busy=1, → IDLE.
- read_enabled is low in every state except ISSUE. Read addresses keep their last value outside ISSUE.
- Handshake rules:
  - out_valid never drops, and out_addr/out_data never change, while waiting for out_ready.
  - out_valid does not depend combinationally on out_ready.
- Back-pressure: the stream may stall indefinitely in EMIT_S or EMIT_T. The register file is not re-read during a stall; captured values are emitted as captured.
- Timing with out_ready held high and READ_LATENCY=1:
  - start sampled at edge 0; ISSUE for pair p in cycle 1+3p.
  - Last word (register 31) in cycle 48; finish in cycle 49; IDLE in cycle 50.
  - In general, 16*(READ_LATENCY+2) cycles of traffic.
- start while busy is ignored and does not queue. start in the DONE cycle is ignored. start in the first IDLE cycle after DONE begins a new dump.
- The pair counter is 4 bits and wraps only via reset to 0 at the next start. It never increments past 15.
- Register 0 is dumped like any other register; whatever the file returns is emitted.

Decomposition:
- Shared package rf_pkg:
  - state enum rf_dump_state_t {IDLE, ISSUE, EMIT_S, EMIT_T, DONE};
  - constants RF_DATA_WIDTH=32, RF_ADDR_WIDTH=5, RF_DEPTH=32.
  - The register file and its benches use the same constants.
- No sub-module is required. Optionally, the two-entry capture buffer plus output mux can be split into rf_dump_buf. The FSM and counters stay in rf_dump_ctrl.

Test Plan:
- Preload the file via its write port (r0=DEADBEEF, r1=00000000, r2=11111111 … r16=FFFFFFFF, r17=00000001 … r30=0000000E, r31=DEADBEEF). Pulse start with out_ready=1 → 32 words, addresses 0..31 in order, data matching the preload, out_last only on addr 31, finish in cycle 49, busy low from cycle 50.
- Same preload; drop out_ready for 5 cycles while out_addr=2 is presented → out_valid, out_addr=2 and out_data=11111111 held all 5 cycles. Word 3 (22222222) follows the cycle after ready returns. No read_enabled during the stall.
- READ_LATENCY=3 build, RF model with 3-cycle latency → addresses held 3 cycles per pair, every word correct, finish in cycle 81.
- Pulse start again at cycles 10 and 30 of a running dump → no effect: exactly 32 words and one finish.
- Assert reset in cycle 20 of a dump → all outputs 0 immediately, state IDLE. A new start then dumps from register 0 with correct data.
- Idle check: start never asserted for 100 cycles → read_enabled, out_valid, busy and finish all stay 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and dump controller state encoding
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DEPTH      = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        EMIT_S,
        EMIT_T,
        DONE
    } rf_dump_state_t;

endpackage

// File: rtl/rf_dump_if.sv
// rf_dump_if: register-file read port plus valid/ready dump stream
//   master (dump controller): drives read_enabled/read_addr_s/read_addr_t and the out_* stream, takes outA/outB/out_ready
//   slave  (file + sink side): the mirror image
interface rf_dump_if #(
    parameter int DW = 32,
    parameter int AW = 5
);

    logic          read_enabled;
    logic [AW-1:0] read_addr_s;
    logic [AW-1:0] read_addr_t;
    logic [DW-1:0] outA;
    logic [DW-1:0] outB;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output read_enabled, read_addr_s, read_addr_t, out_valid, out_addr, out_data, out_last,
        input  outA, outB, out_ready
    );

    modport slave (
        input  read_enabled, read_addr_s, read_addr_t, out_valid, out_addr, out_data, out_last,
        output outA, outB, out_ready
    );

endinterface

// File: rtl/rf_dump_buf.sv
// rf_dump_buf: two-entry capture buffer for an even/odd register pair plus output mux
//   clock, reset : clock and asynchronous active-high reset
//   capture      : load s_in/t_in into the buffers
//   en, sel_t    : drive data with buf_t (sel_t=1) or buf_s; zero when en=0
//   data         : selected word
module rf_dump_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic                  en,
    input  logic                  sel_t,
    input  logic [DATA_WIDTH-1:0] s_in,
    input  logic [DATA_WIDTH-1:0] t_in,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] buf_s, buf_t;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_s <= '0;
            buf_t <= '0;
        end else if (capture) begin
            buf_s <= s_in;
            buf_t <= t_in;
        end
    end

    assign data = en ? (sel_t ? buf_t : buf_s) : '0;

endmodule

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: sweeps the 32-entry register file pairwise and streams {address, data}
//   clock, reset : clock and asynchronous active-high reset
//   start        : dump request, sampled only in IDLE
//   busy, finish : high outside IDLE / one-cycle pulse after the last word is accepted
//   bus          : register-file read port and out_* valid/ready stream (master side)
module rf_dump_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH   = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      start,
    output logic      busy,
    output logic      finish,
    rf_dump_if.master bus
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_ISSUE  = ISSUE;
    localparam logic [2:0] ST_EMIT_S = EMIT_S;
    localparam logic [2:0] ST_EMIT_T = EMIT_T;
    localparam logic [2:0] ST_DONE   = DONE;
    localparam int         PW        = ADDR_WIDTH - 1;
    localparam logic [1:0] WC_INIT   = 2'(READ_LATENCY - 1);

    logic [2:0]    state;
    logic [PW-1:0] p;
    logic [1:0]    wc;
    logic          emit, capture;

    assign emit    = state == ST_EMIT_S || state == ST_EMIT_T;
    assign capture = state == ST_ISSUE && wc == 2'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            p     <= '0;
            wc    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state <= ST_ISSUE;
                    p     <= '0;
                    wc    <= WC_INIT;
                end
                ST_ISSUE: if (capture) state <= ST_EMIT_S; else wc <= wc - 2'd1;
                ST_EMIT_S: if (bus.out_ready) state <= ST_EMIT_T;
                ST_EMIT_T: if (bus.out_ready) begin
                    if (p == '1) state <= ST_DONE;
                    else begin
                        state <= ST_ISSUE;
                        p     <= p + 1'b1;
                        wc    <= WC_INIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read addresses follow p, so they keep their last value outside ISSUE.
    always_comb begin
        busy             = state != ST_IDLE;
        finish           = state == ST_DONE;
        bus.read_enabled = state == ST_ISSUE;
        bus.read_addr_s  = {p, 1'b0};
        bus.read_addr_t  = {p, 1'b1};
        bus.out_valid    = emit;
        bus.out_addr     = emit ? {p, state == ST_EMIT_T} : '0;
        bus.out_last     = state == ST_EMIT_T && p == '1;
    end

    rf_dump_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clock   (clock),
        .reset   (reset),
        .capture (capture),
        .en      (emit),
        .sel_t   (state == ST_EMIT_T),
        .s_in    (bus.outA),
        .t_in    (bus.outB),
        .data    (bus.out_data)
    );

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: directed checks of rf_dump_ctrl with 1-cycle and 3-cycle register-file models
module tb_rf_dump_ctrl;
    import rf_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start1 = 1'b0, start3 = 1'b0, ready = 1'b1;
    logic busy1, fin1, busy3, fin3;
    logic sel = 1'b0;
    int   n_tests = 0, n_fail = 0;

    logic [31:0] mem [RF_DEPTH];
    logic [31:0] s1, s2, t1, t2;

    rf_dump_if #(.DW(RF_DATA_WIDTH), .AW(RF_ADDR_WIDTH)) b1 ();
    rf_dump_if #(.DW(RF_DATA_WIDTH), .AW(RF_ADDR_WIDTH)) b3 ();

    rf_dump_ctrl #(.READ_LATENCY(1)) u1 (.clock(clock), .reset(reset), .start(start1), .busy(busy1), .finish(fin1), .bus(b1));
    rf_dump_ctrl #(.READ_LATENCY(3)) u3 (.clock(clock), .reset(reset), .start(start3), .busy(busy3), .finish(fin3), .bus(b3));

    always #5 clock = ~clock;

    // Register-file models; a sentinel is returned whenever read_enabled is low.
    assign b1.outA      = b1.read_enabled ? mem[b1.read_addr_s] : 32'hBAD0_BAD0;
    assign b1.outB      = b1.read_enabled ? mem[b1.read_addr_t] : 32'hBAD1_BAD1;
    assign b1.out_ready = ready;

    always_ff @(posedge clock) begin
        s1 <= b3.read_enabled ? mem[b3.read_addr_s] : 32'hBAD0_BAD0;
        t1 <= b3.read_enabled ? mem[b3.read_addr_t] : 32'hBAD1_BAD1;
        s2 <= s1;
        t2 <= t1;
    end
    assign b3.outA      = s2;
    assign b3.outB      = t2;
    assign b3.out_ready = ready;

    logic        m_valid, m_last, m_busy, m_fin, m_re;
    logic [4:0]  m_addr, m_as, m_at;
    logic [31:0] m_data;
    always_comb begin
        m_valid = sel ? b3.out_valid    : b1.out_valid;
        m_last  = sel ? b3.out_last     : b1.out_last;
        m_addr  = sel ? b3.out_addr     : b1.out_addr;
        m_data  = sel ? b3.out_data     : b1.out_data;
        m_re    = sel ? b3.read_enabled : b1.read_enabled;
        m_as    = sel ? b3.read_addr_s  : b1.read_addr_s;
        m_at    = sel ? b3.read_addr_t  : b1.read_addr_t;
        m_busy  = sel ? busy3           : busy1;
        m_fin   = sel ? fin3            : fin1;
    end

    function automatic logic [31:0] rv(input int k);
        if (k == 0 || k == 31) return 32'hDEAD_BEEF;
        if (k == 1) return 32'h0;
        if (k <= 16) return 32'(k - 1) * 32'h1111_1111;
        return 32'(k - 16);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start3 = v; else start1 = v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 64'(m_valid), 64'd0);
        check({tag, " busy"},  64'(m_busy),  64'd0);
        check({tag, " fin"},   64'(m_fin),   64'd0);
        check({tag, " re"},    64'(m_re),    64'd0);
        check({tag, " addr"},  {32'(m_as), 32'(m_addr)}, 64'd0);
        check({tag, " data"},  64'(m_data), 64'd0);
        check({tag, " last"},  64'(m_last), 64'd0);
    endtask

    // Runs one dump; cycle 1 is the cycle after the edge that samples start.
    task automatic run_dump(input logic lat3, input int stall_addr, input int stall_len,
                            input int r1, input int r2, input int exp_fin);
        int words = 0, fins = 0, fin_cyc = -1, re_cyc = 0, stall_left = 0, ret_cyc = -1;
        bit stall_done = 0;
        sel = lat3;
        ready = 1'b1;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            set_start(cyc == r1 || cyc == r2);
            if (!stall_done && stall_addr >= 0 && m_valid && m_addr == 5'(stall_addr)) begin
                stall_done = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                ready = 1'b0;
                check("stall valid", 64'(m_valid), 64'd1);
                check("stall addr",  64'(m_addr),  64'(stall_addr));
                check("stall data",  64'(m_data),  64'(rv(stall_addr)));
                check("stall re",    64'(m_re),    64'd0);
                stall_left--;
                if (stall_left == 0) ret_cyc = cyc + 1;
            end else ready = 1'b1;
            if (m_re) begin
                re_cyc++;
                check("addr t", 64'(m_at), 64'(m_as) + 64'd1);
            end
            if (m_valid && ready) begin
                check("word addr", 64'(m_addr), 64'(words));
                check("word data", 64'(m_data), 64'(rv(words)));
                check("word last", 64'(m_last), 64'(words == 31));
                if (stall_addr >= 0 && words == stall_addr + 1)
                    check("resume cycle", 64'(cyc), 64'(ret_cyc + 1));
                words++;
            end
            if (m_fin) begin
                fins++;
                fin_cyc = cyc;
            end
            if (fin_cyc > 0 && cyc == fin_cyc + 1) begin
                check("busy after", 64'(m_busy), 64'd0);
                break;
            end
            tick();
        end
        set_start(1'b0);
        ready = 1'b1;
        check("word count",   64'(words),   64'd32);
        check("finish count", 64'(fins),    64'd1);
        check("finish cycle", 64'(fin_cyc), 64'(exp_fin));
        check("re cycles",    64'(re_cyc),  lat3 ? 64'd48 : 64'd16);
        tick();
    endtask

    initial begin
        bit seen = 0;
        for (int i = 0; i < RF_DEPTH; i++) mem[i] = rv(i);
        repeat (3) tick();
        sel = 0;
        check_zero("reset1");
        sel = 1;
        check_zero("reset3");
        reset = 1'b0;
        tick();
        run_dump(1'b0, -1, 0, -1, -1, 49);
        run_dump(1'b0, 2, 5, -1, -1, 54);
        run_dump(1'b1, -1, 0, -1, -1, 81);
        run_dump(1'b0, -1, 0, 10, 30, 49);
        sel = 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (19) tick();
        check("mid busy", 64'(m_busy), 64'd1);
        reset = 1'b1;
        #1;
        check_zero("mid reset");
        tick();
        reset = 1'b0;
        tick();
        run_dump(1'b0, -1, 0, -1, -1, 49);
        for (int i = 0; i < 100; i++) begin
            if (b1.read_enabled || b1.out_valid || busy1 || fin1 ||
                b3.read_enabled || b3.out_valid || busy3 || fin3) seen = 1;
            tick();
        end
        check("idle activity", 64'(seen), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
